pwl_slope_precompute: RTL and testbench
=======================================

Name: pwl_slope_precompute

Overview:
Upstream neighbour of the PWL wave generator. Accepts a DMA stream of raw breakpoints {time, sample} and pairs each point with its successor. For each point it computes the signed segment slope, delta sample / delta time, using an iterative divider. It emits {time, sample, slope} words in the lane order the PWL generator splices: slope lane 0, sample lane 1, time lane 2.

Parameters:
SAMPLE_WIDTH, 16, width of sample, time and slope fields
IN_WIDTH, 32, input word width; time in [31:16], sample in [15:0]
OUT_WIDTH, 48, output word width; {time, sample, slope}

Ports:
clk  in  1  system clock; only clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
s_data  in  IN_WIDTH  breakpoint {time, sample}
s_valid  in  1  input word valid
s_last  in  1  final breakpoint of the wave
s_ready  out  1  block can accept input
m_data  out  OUT_WIDTH  {time, sample, slope} of the held point
m_valid  out  1  output word valid
m_last  out  1  final output word; drives the generator's dma.done
m_ready  in  1  downstream accepts
err_dt  out  1  sticky: a segment had delta time <= 0

Behaviour:
- Reset, async assert / sync release: state IDLE; s_ready=0, m_valid=0, m_last=0, m_data=0, err_dt=0. s_ready goes to 1 on the first clk after release.
- Input transfer is s_valid&&s_ready; output transfer is m_valid&&m_ready. m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Arithmetic:
  - ds = sext(s1)-sext(s0), 17-bit signed.
  - dt = t1-t0, 17-bit signed. If dt<=0: slope=0, err_dt set (sticky until reset).
  - Otherwise slope = |ds|/dt restoring division, truncated toward zero, sign reapplied.
  - Result saturates to [-32768, 32767].
- States:
  - IDLE: s_ready=1. On transfer, latch point P. If s_last, go to EMIT_LAST; else go to WAIT_NEXT.
  - WAIT_NEXT: s_ready=1. On transfer, latch Q and its last flag, start the divider, go to DIVIDE.
  - DIVIDE: s_ready=0. Runs exactly 17 cycles, one quotient bit per cycle; dt<=0 also takes 17 cycles for fixed latency. Then m_data={P.time, P.sample, slope}, m_valid=1, go to EMIT.
  - EMIT: on output transfer P<=Q. If Q was last, go to EMIT_LAST; else go to WAIT_NEXT.
  - EMIT_LAST: m_data={P.time, P.sample, 0}, m_valid=1, m_last=1. On transfer go to IDLE with m_last=0.
- Latency: second point accepted -> m_valid after 18 cycles.
- Throughput: one point per ~19 cycles, acceptable because the PWL tables are small.
- A single-point wave (first word carries s_last) emits one word with slope 0 and m_last=1.
- s_valid while s_ready=0 is ignored; the word is held by the source.
- Reset mid-DIVIDE or mid-EMIT discards all state with no partial output.
- Time wrap is not supported: a decreasing time gives err_dt and slope 0.

Optional Feature:
PWL_SLOPE_ROUND_EN
- Defined: quotient rounds to nearest, halves away from zero. Divider runs one extra cycle (18), and the remainder compare (2*rem >= dt) increments the magnitude before the sign is applied; saturation still applies.
- Undefined: truncation toward zero, 17-cycle divide.

Decomposition:
- Package pwl_pkg holds:
  - typedef pwl_point_t {time, sample}
  - typedef pwl_seg_t {time, sample, slope}
  - localparams SLOPE_MAX / SLOPE_MIN, DIV_CYCLES
- Sub-module pwl_slope_divider:
  - inputs: start, ds, dt
  - outputs: busy, done pulse, quotient (17-bit signed, pre-saturation), dt_err
  - all sequencing logic stays in the top.

Test Plan:
- Slopes and last word: input (t0,s0),(t10,s100),(t20,s50,last).
  - Outputs: {0,0,10}, {10,100,-5}, {20,50,0} with m_last only on the third.
- Rounding: (0,0)->(3,7) gives slope 2 in both builds. (0,0)->(2,-7) gives -3 without the macro and -4 with PWL_SLOPE_ROUND_EN.
- Saturation and dt errors:
  - (0,-32768)->(1,32767) gives slope 32767.
  - Equal times (5,0)->(5,9) gives slope 0 and err_dt=1, held after further valid segments.
- Backpressure: hold m_ready=0 for 20 cycles during EMIT.
  - m_data stays constant; s_ready=0; no word is lost or duplicated.
  - Random s_valid gaps give an identical output sequence.
- Single point and reset:
  - A single word with s_last gives one output, slope 0, m_last=1.
  - rst low in DIVIDE cycle 8 forces immediate outputs 0 and a fresh IDLE; a subsequent wave produces correct slopes.

Source files
------------

// File: rtl/pwl_pkg.sv
// Shared types and constants for the PWL slope precompute block.
// PWL_SLOPE_ROUND_EN selects round-to-nearest quotients and one extra divide cycle.
package pwl_pkg;
  localparam int PWL_SW = 16;

  localparam logic signed [16:0] SLOPE_MAX = 17'sd32767;
  localparam logic signed [16:0] SLOPE_MIN = -17'sd32768;

`ifdef PWL_SLOPE_ROUND_EN
  localparam logic [4:0] DIV_CYCLES = 5'd18;
`else
  localparam logic [4:0] DIV_CYCLES = 5'd17;
`endif

  typedef struct packed {
    logic [PWL_SW-1:0] tm;
    logic [PWL_SW-1:0] sample;
  } pwl_point_t;

  typedef struct packed {
    logic [PWL_SW-1:0] tm;
    logic [PWL_SW-1:0] sample;
    logic [PWL_SW-1:0] slope;
  } pwl_seg_t;

  function automatic logic [PWL_SW-1:0] sat_slope(input logic signed [16:0] q);
    if (q > SLOPE_MAX)      return 16'h7fff;
    else if (q < SLOPE_MIN) return 16'h8000;
    else                    return q[15:0];
  endfunction
endpackage

// File: rtl/pwl_slope_divider.sv
// Restoring sign-magnitude divider: one quotient bit per cycle, fixed latency.
// PWL_SLOPE_ROUND_EN adds a final round-half-away-from-zero cycle.
module pwl_slope_divider
  import pwl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [16:0] ds,
  input  logic signed [16:0] dt,
  output logic               busy,
  output logic               done,
  output logic signed [16:0] quotient,
  output logic               dt_err
);

  logic [4:0]  cnt_q, cnt_d;
  logic [16:0] dvd_q, dvd_d;
  logic [16:0] dvs_q, dvs_d;
  logic [16:0] rem_q, rem_d;
  logic [16:0] quo_q, quo_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [17:0] rem_sh, rem_sub;
  logic        round_step;

  always_comb begin
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    neg_d      = neg_q;
    err_d      = err_q;
    done_d     = 1'b0;
    rem_sh     = {rem_q, dvd_q[16]};
    rem_sub    = rem_sh - {1'b0, dvs_q};
    round_step = 1'b0;
`ifdef PWL_SLOPE_ROUND_EN
    round_step = (cnt_q == 5'd1);
`endif
    if (start) begin
      cnt_d = DIV_CYCLES;
      dvd_d = ds[16] ? 17'(-ds) : 17'(ds);
      dvs_d = 17'(dt);
      rem_d = '0;
      quo_d = '0;
      neg_d = ds[16];
      err_d = (dt <= 17'sd0);
    end else if (cnt_q != 5'd0) begin
      cnt_d  = cnt_q - 5'd1;
      done_d = (cnt_q == 5'd1);
      if (round_step) begin
        // remainder is below the divisor, so the doubled value fits 18 bits
        if ({rem_q, 1'b0} >= {1'b0, dvs_q}) quo_d = quo_q + 17'd1;
      end else begin
        dvd_d = {dvd_q[15:0], 1'b0};
        if (!rem_sub[17]) begin
          rem_d = rem_sub[16:0];
          quo_d = {quo_q[15:0], 1'b1};
        end else begin
          rem_d = rem_sh[16:0];
          quo_d = {quo_q[15:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      neg_q  <= neg_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  assign busy     = (cnt_q != 5'd0);
  assign done     = done_q;
  assign dt_err   = err_q;
  assign quotient = err_q ? 17'sd0 : (neg_q ? -$signed(quo_q) : $signed(quo_q));

endmodule

// File: rtl/pwl_slope_precompute.sv
// Pairs successive PWL breakpoints and emits {time, sample, slope} words.
// PWL_SLOPE_ROUND_EN (see divider) switches slopes to round-to-nearest.
//
// state     | meaning
// IDLE      | waiting for first point of a wave
// WAIT_NEXT | holding P, waiting for successor Q
// DIVIDE    | divider computing slope P->Q
// EMIT      | presenting P with its slope
// EMIT_LAST | presenting final point, slope 0, m_last
module pwl_slope_precompute
  import pwl_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 err_dt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_NEXT = 3'd1;
  localparam logic [2:0] DIVIDE    = 3'd2;
  localparam logic [2:0] EMIT      = 3'd3;
  localparam logic [2:0] EMIT_LAST = 3'd4;

  logic [2:0] state_q, state_d;
  pwl_point_t p_q, p_d, q_q, q_d, s_pt;
  pwl_seg_t   m_data_q, m_data_d;
  logic       q_last_q, q_last_d;
  logic       s_ready_q, s_ready_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q, m_last_d;
  logic       err_dt_q, err_dt_d;
  logic       s_xfer, m_xfer, div_start;
  logic       div_busy, div_done, div_dt_err;
  logic signed [SAMPLE_WIDTH:0] ds, dt, div_quo;

  assign s_pt   = pwl_point_t'(s_data[2*PWL_SW-1:0]);
  assign s_xfer = s_valid && s_ready_q;
  assign m_xfer = m_valid_q && m_ready;
  assign ds     = $signed({s_pt.sample[15], s_pt.sample}) - $signed({p_q.sample[15], p_q.sample});
  assign dt     = $signed({1'b0, s_pt.tm}) - $signed({1'b0, p_q.tm});

  pwl_slope_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .ds       (ds),
    .dt       (dt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .dt_err   (div_dt_err)
  );

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    q_last_d  = q_last_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    err_dt_d  = err_dt_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (s_xfer) begin
        p_d = s_pt;
        if (s_last) begin
          m_data_d  = '{tm: s_pt.tm, sample: s_pt.sample, slope: '0};
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          state_d   = EMIT_LAST;
        end else begin
          state_d = WAIT_NEXT;
        end
      end
      WAIT_NEXT: if (s_xfer) begin
        q_d       = s_pt;
        q_last_d  = s_last;
        div_start = 1'b1;
        state_d   = DIVIDE;
      end
      DIVIDE: if (div_done && !div_busy) begin
        m_data_d  = '{tm: p_q.tm, sample: p_q.sample, slope: sat_slope(div_quo)};
        m_valid_d = 1'b1;
        err_dt_d  = err_dt_q | div_dt_err;
        state_d   = EMIT;
      end
      EMIT: if (m_xfer) begin
        p_d = q_q;
        if (q_last_q) begin
          // final point follows back-to-back; m_valid stays high with new data
          m_data_d = '{tm: q_q.tm, sample: q_q.sample, slope: '0};
          m_last_d = 1'b1;
          state_d  = EMIT_LAST;
        end else begin
          m_valid_d = 1'b0;
          state_d   = WAIT_NEXT;
        end
      end
      EMIT_LAST: if (m_xfer) begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d == IDLE) || (state_d == WAIT_NEXT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      q_q       <= '0;
      q_last_q  <= 1'b0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      err_dt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      q_last_q  <= q_last_d;
      m_data_q  <= m_data_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      err_dt_q  <= err_dt_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_data  = OUT_WIDTH'(m_data_q);
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign err_dt  = err_dt_q;

endmodule

// File: tb/tb_pwl_slope_precompute.sv
// Directed bench for pwl_slope_precompute; expectations follow PWL_SLOPE_ROUND_EN.
module tb_pwl_slope_precompute;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [47:0] m_data;
  logic        m_valid, m_last, m_ready, err_dt;
  int          tests = 0;
  int          fails = 0;
  bit          gaps  = 1'b0;

`ifdef PWL_SLOPE_ROUND_EN
  localparam int          LAT      = 19;
  localparam logic [15:0] RND_NEG7 = 16'hfffc;
`else
  localparam int          LAT      = 18;
  localparam logic [15:0] RND_NEG7 = 16'hfffd;
`endif

  always #5 clk = ~clk;

  pwl_slope_precompute dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .err_dt(err_dt)
  );

  task automatic send(input logic [15:0] t, input logic [15:0] s, input logic last);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    s_data = {t, s}; s_valid = 1'b1; s_last = last;
    while (!s_ready && n < 400) begin @(posedge clk); #1; n++; end
    if (s_ready) begin @(posedge clk); #1; end
    else begin
      tests++; fails++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic recv(output logic [47:0] d, output logic l);
    int n = 0;
    m_ready = 1'b0;
    while (!m_valid && n < 400) begin @(posedge clk); #1; n++; end
    if (gaps) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    if (m_valid) begin
      d = m_data; l = m_last;
      m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
    end else begin
      d = '0; l = 1'b0;
      tests++; fails++;
      $display("FAIL recv_timeout: m_valid=%b after %0d cycles, required 1", m_valid, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
    tests++; if (m_last  !== 1'b0) begin fails++; $display("FAIL rst_m_last: got %b required 0", m_last); end
    tests++; if (m_data  !== 48'h0) begin fails++; $display("FAIL rst_m_data: got %h required 0", m_data); end
    tests++; if (err_dt  !== 1'b0) begin fails++; $display("FAIL rst_err_dt: got %b required 0", err_dt); end
    rst = 1'b1;
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rel_s_ready_early: got %b required 0", s_ready); end
    @(posedge clk); #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rel_s_ready: got %b required 1", s_ready); end
  endtask

  task automatic test_slopes(input string tag);
    logic [47:0] d; logic l; int n = 0;
    send(16'd0, 16'd0, 1'b0);
    send(16'd10, 16'd100, 1'b0);
    if (!gaps) begin
      while (!m_valid && n < 40) begin @(posedge clk); #1; n++; end
      tests++; if (n != LAT) begin fails++; $display("FAIL %s_latency: got %0d required %0d", tag, n, LAT); end
    end
    recv(d, l);
    tests++; if ({d, l} !== {48'h0000_0000_000a, 1'b0}) begin fails++; $display("FAIL %s_seg0: got %h/%b required 00000000000a/0", tag, d, l); end
    send(16'd20, 16'd50, 1'b1);
    recv(d, l);
    tests++; if ({d, l} !== {48'h000a_0064_fffb, 1'b0}) begin fails++; $display("FAIL %s_seg1: got %h/%b required 000a0064fffb/0", tag, d, l); end
    recv(d, l);
    tests++; if ({d, l} !== {48'h0014_0032_0000, 1'b1}) begin fails++; $display("FAIL %s_seg2: got %h/%b required 001400320000/1", tag, d, l); end
    tests++; if (err_dt !== 1'b0) begin fails++; $display("FAIL %s_no_err: got %b required 0", tag, err_dt); end
  endtask

  task automatic test_rounding;
    logic [47:0] d; logic l;
    send(16'd0, 16'd0, 1'b0); send(16'd3, 16'd7, 1'b1);
    recv(d, l);
    tests++; if (d !== 48'h0000_0000_0002) begin fails++; $display("FAIL round_7_3: got %h required 000000000002", d); end
    recv(d, l);
    tests++; if ({d, l} !== {48'h0003_0007_0000, 1'b1}) begin fails++; $display("FAIL round_7_3_last: got %h/%b required 000300070000/1", d, l); end
    send(16'd0, 16'd0, 1'b0); send(16'd2, 16'hfff9, 1'b1);
    recv(d, l);
    tests++; if (d !== {32'h0, RND_NEG7}) begin fails++; $display("FAIL round_m7_2: got %h required %h", d, {32'h0, RND_NEG7}); end
    recv(d, l);
  endtask

  task automatic test_saturation;
    logic [47:0] d; logic l;
    send(16'd0, 16'h8000, 1'b0); send(16'd1, 16'h7fff, 1'b1);
    recv(d, l);
    tests++; if (d !== 48'h0000_8000_7fff) begin fails++; $display("FAIL sat_pos: got %h required 000080007fff", d); end
    recv(d, l);
    send(16'd0, 16'h7fff, 1'b0); send(16'd1, 16'h8000, 1'b1);
    recv(d, l);
    tests++; if (d !== 48'h0000_7fff_8000) begin fails++; $display("FAIL sat_neg: got %h required 00007fff8000", d); end
    recv(d, l);
  endtask

  task automatic test_dt_err;
    logic [47:0] d; logic l;
    send(16'd5, 16'd0, 1'b0); send(16'd5, 16'd9, 1'b0);
    recv(d, l);
    tests++; if (d !== 48'h0005_0000_0000) begin fails++; $display("FAIL dt0_slope: got %h required 000500000000", d); end
    tests++; if (err_dt !== 1'b1) begin fails++; $display("FAIL dt0_err: got %b required 1", err_dt); end
    send(16'd15, 16'd19, 1'b1);
    recv(d, l);
    tests++; if (d !== 48'h0005_0009_0001) begin fails++; $display("FAIL dt_after_err: got %h required 000500090001", d); end
    recv(d, l);
    tests++; if (err_dt !== 1'b1) begin fails++; $display("FAIL dt_err_sticky: got %b required 1", err_dt); end
  endtask

  task automatic test_backpressure;
    logic [47:0] d, snap; logic l; int n = 0;
    send(16'd0, 16'd0, 1'b0); send(16'd4, 16'd40, 1'b0);
    while (!m_valid && n < 40) begin @(posedge clk); #1; n++; end
    snap = m_data;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tests++;
      if (m_data !== snap || s_ready !== 1'b0 || m_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold_%0d: got %h/rdy%b/v%b required %h/rdy0/v1", i, m_data, s_ready, m_valid, snap);
      end
    end
    recv(d, l);
    tests++; if (d !== 48'h0000_0000_000a) begin fails++; $display("FAIL bp_seg0: got %h required 00000000000a", d); end
    send(16'd8, 16'd0, 1'b1);
    recv(d, l);
    tests++; if (d !== 48'h0004_0028_fff6) begin fails++; $display("FAIL bp_seg1: got %h required 00040028fff6", d); end
    recv(d, l);
    tests++; if ({d, l} !== {48'h0008_0000_0000, 1'b1}) begin fails++; $display("FAIL bp_seg2: got %h/%b required 000800000000/1", d, l); end
    repeat (3) @(posedge clk); #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got m_valid %b required 0", m_valid); end
  endtask

  task automatic test_single;
    logic [47:0] d; logic l;
    send(16'd7, 16'd123, 1'b1);
    recv(d, l);
    tests++; if ({d, l} !== {48'h0007_007b_0000, 1'b1}) begin fails++; $display("FAIL single: got %h/%b required 0007007b0000/1", d, l); end
    repeat (3) @(posedge clk); #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL single_once: got m_valid %b required 0", m_valid); end
  endtask

  task automatic test_reset_mid;
    logic [47:0] d; logic l; int n = 0;
    send(16'd0, 16'd0, 1'b0); send(16'd10, 16'd20, 1'b0);
    repeat (8) @(posedge clk);
    #1; rst = 1'b0; #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== 48'h0 || s_ready !== 1'b0 || err_dt !== 1'b0 || m_last !== 1'b0) begin
      fails++; $display("FAIL rst_div: got v%b d%h r%b e%b l%b required all 0", m_valid, m_data, s_ready, err_dt, m_last);
    end
    @(posedge clk); #1; rst = 1'b1;
    send(16'd0, 16'd0, 1'b0); send(16'd1, 16'd1, 1'b0);
    while (!m_valid && n < 40) begin @(posedge clk); #1; n++; end
    rst = 1'b0; #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== 48'h0) begin
      fails++; $display("FAIL rst_emit: got v%b d%h required v0 d0", m_valid, m_data);
    end
    @(posedge clk); #1; rst = 1'b1;
    send(16'd0, 16'd0, 1'b0); send(16'd10, 16'd30, 1'b1);
    recv(d, l);
    tests++; if ({d, l} !== {48'h0000_0000_0003, 1'b0}) begin fails++; $display("FAIL post_rst_seg0: got %h/%b required 000000000003/0", d, l); end
    recv(d, l);
    tests++; if ({d, l} !== {48'h000a_001e_0000, 1'b1}) begin fails++; $display("FAIL post_rst_seg1: got %h/%b required 000a001e0000/1", d, l); end
  endtask

  initial begin
    test_reset();
    test_slopes("slopes");
    test_rounding();
    test_saturation();
    test_backpressure();
    gaps = 1'b1;
    test_slopes("gaps");
    gaps = 1'b0;
    test_single();
    test_dt_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
